cga_alu_mdseq: RTL and testbench

CGA_ALU_MDSEQ -- requirements
Module: cga_alu_mdseq

---
 rtl/cga_alu_mdseq.sv | 193 +++++++++++++++++++
 tb/tb_cga_alu_mdseq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_alu_mdseq.sv
// rtl/cga_alu_mdseq.sv - 16-bit unsigned multiply/divide sequencer driving an external RALU
//
// Purpose:
//    Runs a 16-iteration shift/add multiply or restoring divide. Each iteration
//    does one pass through an external combinational RALU, which is driven
//    through the ralu_* outputs and returns ralu_f/ralu_cry in the same cycle.
//
// Ports:
//    sysclk      in   1   sole clock, rising edge
//    sys_rst_n   in   1   asynchronous active-low reset
//    start       in   1   request an operation, sampled only in IDLE
//    op          in   1   0 = unsigned multiply, 1 = unsigned divide
//    opa         in  16   multiplicand / dividend
//    opb         in  16   multiplier / divisor
//    ralu_rn     out 16   RALU RN operand
//    ralu_s      out 16   RALU S operand
//    ralu_log, ralu_fsel, ralu_alui4, ralu_rsn, ralu_ci  out 1  RALU control
//    ralu_f      in  16   RALU result
//    ralu_cry    in   1   RALU carry out (1 = carry / no borrow)
//    busy        out  1   state is not IDLE
//    done        out  1   one-cycle result-valid pulse
//    res_hi      out 16   product[31:16] / remainder
//    res_lo      out 16   product[15:0]  / quotient
//    ovf         out  1   multiply result exceeds 16 bits
//    dz          out  1   divide by zero

`timescale 1ns/1ps

module cga_alu_mdseq (
   input  logic        sysclk,
   input  logic        sys_rst_n,
   input  logic        start,
   input  logic        op,
   input  logic [15:0] opa,
   input  logic [15:0] opb,
   output logic [15:0] ralu_rn,
   output logic [15:0] ralu_s,
   output logic        ralu_log,
   output logic        ralu_fsel,
   output logic        ralu_alui4,
   output logic        ralu_rsn,
   output logic        ralu_ci,
   input  logic [15:0] ralu_f,
   input  logic        ralu_cry,
   output logic        busy,
   output logic        done,
   output logic [15:0] res_hi,
   output logic [15:0] res_lo,
   output logic        ovf,
   output logic        dz
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_a;
   logic [15:0] r_q;
   logic [15:0] r_m;
   logic [3:0]  r_cnt;
   logic        r_opr;
   logic        r_ovf;
   logic        r_dz;

   logic [15:0] w_shifted;
   logic [15:0] w_a_nxt;
   logic [15:0] w_q_nxt;
   logic        w_div_zero;

   assign w_div_zero = op && (opb == 16'h0000);

   // State register
   always_ff @(posedge sysclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, RALU drive and per-iteration datapath update
   always_comb begin
      w_state_nxt = r_state;
      ralu_rn     = 16'h0000;
      ralu_s      = 16'h0000;
      ralu_log    = 1'b0;
      ralu_fsel   = 1'b0;
      ralu_alui4  = 1'b0;
      ralu_rsn    = 1'b0;
      ralu_ci     = 1'b0;
      w_shifted   = {r_a[14:0], r_q[15]};
      w_a_nxt     = r_a;
      w_q_nxt     = r_q;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = w_div_zero ? ST_DONE : ST_ITER;
            end
         end
         ST_ITER: begin
            if (!r_opr) begin
               // Multiply: add M when the current multiplier bit is set, then
               // shift the 33-bit {carry, A, Q} right by one.
               ralu_rn = r_a;
               ralu_s  = r_q[0] ? r_m : 16'h0000;
               w_a_nxt = {ralu_cry, ralu_f[15:1]};
               w_q_nxt = {ralu_f[0], r_q[15:1]};
            end else begin
               // Restoring divide: trial-subtract M from the shifted partial
               // remainder. The bit shifted out of A counts as bit 16, so a set
               // A[15] means the subtraction always fits.
               ralu_rn    = w_shifted;
               ralu_s     = r_m;
               ralu_alui4 = 1'b1;
               ralu_ci    = 1'b1;
               if (r_a[15] || ralu_cry) begin
                  w_a_nxt = ralu_f;
                  w_q_nxt = {r_q[14:0], 1'b1};
               end else begin
                  w_a_nxt = w_shifted;
                  w_q_nxt = {r_q[14:0], 1'b0};
               end
            end
            if (r_cnt == 4'd15) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge sysclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_a   <= 16'h0000;
         r_q   <= 16'h0000;
         r_m   <= 16'h0000;
         r_cnt <= 4'd0;
         r_opr <= 1'b0;
         r_ovf <= 1'b0;
         r_dz  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_m   <= opb;
                  r_cnt <= 4'd0;
                  r_opr <= op;
                  r_ovf <= 1'b0;
                  if (w_div_zero) begin
                     // Present dividend as remainder and all-ones quotient.
                     r_a  <= opa;
                     r_q  <= 16'hFFFF;
                     r_dz <= 1'b1;
                  end else begin
                     r_a  <= 16'h0000;
                     r_q  <= opa;
                     r_dz <= 1'b0;
                  end
               end
            end
            ST_ITER: begin
               r_a   <= w_a_nxt;
               r_q   <= w_q_nxt;
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'd15) begin
                  r_ovf <= !r_opr && (w_a_nxt != 16'h0000);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy   = (r_state != ST_IDLE);
   assign done   = (r_state == ST_DONE);
   assign res_hi = r_a;
   assign res_lo = r_q;
   assign ovf    = r_ovf;
   assign dz     = r_dz;

endmodule

// File: tb/tb_cga_alu_mdseq.sv
// tb/tb_cga_alu_mdseq.sv - scoreboard bench for cga_alu_mdseq with a behavioural RALU

`timescale 1ns/1ps

module tb_cga_alu_mdseq;

   logic        sysclk;
   logic        sys_rst_n;
   logic        start;
   logic        op;
   logic [15:0] opa;
   logic [15:0] opb;
   logic [15:0] ralu_rn;
   logic [15:0] ralu_s;
   logic        ralu_log;
   logic        ralu_fsel;
   logic        ralu_alui4;
   logic        ralu_rsn;
   logic        ralu_ci;
   logic [15:0] ralu_f;
   logic        ralu_cry;
   logic        busy;
   logic        done;
   logic [15:0] res_hi;
   logic [15:0] res_lo;
   logic        ovf;
   logic        dz;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [15:0] hi;
      logic [15:0] lo;
      logic        ovf;
      logic        dz;
      int          lat;
   } exp_t;

   exp_t sb[$];

   cga_alu_mdseq dut (
      .sysclk     (sysclk),
      .sys_rst_n  (sys_rst_n),
      .start      (start),
      .op         (op),
      .opa        (opa),
      .opb        (opb),
      .ralu_rn    (ralu_rn),
      .ralu_s     (ralu_s),
      .ralu_log   (ralu_log),
      .ralu_fsel  (ralu_fsel),
      .ralu_alui4 (ralu_alui4),
      .ralu_rsn   (ralu_rsn),
      .ralu_ci    (ralu_ci),
      .ralu_f     (ralu_f),
      .ralu_cry   (ralu_cry),
      .busy       (busy),
      .done       (done),
      .res_hi     (res_hi),
      .res_lo     (res_lo),
      .ovf        (ovf),
      .dz         (dz)
   );

   // Behavioural RALU: ADD is rn + s + ci, SUB is rn + ~s + ci.
   logic [16:0] w_sum;
   assign w_sum    = {1'b0, ralu_rn} + {1'b0, (ralu_alui4 ? ~ralu_s : ralu_s)} + {16'h0000, ralu_ci};
   assign ralu_f   = w_sum[15:0];
   assign ralu_cry = w_sum[16];

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   function automatic exp_t model(input logic o, input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      logic [31:0] p;
      if (!o) begin
         p     = {16'h0000, a} * {16'h0000, b};
         e.hi  = p[31:16];
         e.lo  = p[15:0];
         e.ovf = (p[31:16] != 16'h0000);
         e.dz  = 1'b0;
         e.lat = 17;
      end else if (b == 16'h0000) begin
         e.hi  = a;
         e.lo  = 16'hFFFF;
         e.ovf = 1'b0;
         e.dz  = 1'b1;
         e.lat = 1;
      end else begin
         e.hi  = a % b;
         e.lo  = a / b;
         e.ovf = 1'b0;
         e.dz  = 1'b0;
         e.lat = 17;
      end
      return e;
   endfunction

   function automatic logic [36:0] ralu_bus();
      return {ralu_rn, ralu_s, ralu_log, ralu_fsel, ralu_alui4, ralu_rsn, ralu_ci};
   endfunction

   // Called at a negedge in IDLE. intr: cycle at which a foreign start is
   // pulsed (0 = none). keep: leave start high for the whole operation.
   task automatic do_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                        input int intr, input bit keep);
      exp_t        e;
      exp_t        got;
      int          lat;
      bit          seen;
      logic [36:0] exp_bus;
      e = model(o, a, b);
      sb.push_back(e);
      op    = o;
      opa   = a;
      opb   = b;
      start = 1'b1;
      lat   = 0;
      seen  = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge sysclk);
         lat++;
         if (!keep) start = 1'b0;
         if (lat == 1) begin
            if (e.dz)
               exp_bus = 37'h0;
            else if (o)
               exp_bus = {15'h0000, a[15], b, 5'b00101};
            else
               exp_bus = {16'h0000, (a[0] ? b : 16'h0000), 5'b00000};
            check("ralu_first_cycle", {27'h0, ralu_bus()} >> 27, {27'h0, exp_bus} >> 27);
            check("ralu_first_ctl", {27'h0, ralu_bus()[4:0]}, {27'h0, exp_bus[4:0]});
            check("ralu_first_s", {16'h0, ralu_s}, {16'h0, exp_bus[20:5]});
         end
         if (intr != 0 && lat == intr) begin
            start = 1'b1;
            op    = ~o;
            opa   = ~a;
            opb   = a ^ 16'h5A5A;
         end
         seen = done;
      end
      if (!seen) begin
         check("done_timeout", 32'd0, 32'd1);
         void'(sb.pop_front());
      end else begin
         got = sb.pop_front();
         check("latency", lat, got.lat);
         check("res_hi", {16'h0, res_hi}, {16'h0, got.hi});
         check("res_lo", {16'h0, res_lo}, {16'h0, got.lo});
         check("ovf", {31'h0, ovf}, {31'h0, got.ovf});
         check("dz", {31'h0, dz}, {31'h0, got.dz});
         check("busy_in_done", {31'h0, busy}, 32'd1);
         check("ralu_idle_done", {27'h0, ralu_bus()[4:0]} | {16'h0, ralu_rn}, 32'd0);
      end
   endtask

   task automatic after_done(input logic [15:0] hi, input logic [15:0] lo);
      @(negedge sysclk);
      check("done_pulse_end", {31'h0, done}, 32'd0);
      check("busy_idle", {31'h0, busy}, 32'd0);
      repeat (3) @(negedge sysclk);
      check("result_hold", {res_hi, res_lo}, {hi, lo});
      check("ralu_idle", {27'h0, ralu_bus()[4:0]} | {16'h0, ralu_rn} | {16'h0, ralu_s}, 32'd0);
   endtask

   initial begin
      sys_rst_n = 1'b0;
      start     = 1'b0;
      op        = 1'b0;
      opa       = 16'h0000;
      opb       = 16'h0000;
      repeat (2) @(negedge sysclk);
      check("reset_outputs", {26'h0, busy, done, ovf, dz, 2'b00}, 32'd0);
      check("reset_results", {res_hi, res_lo}, 32'd0);
      check("reset_ralu", {27'h0, ralu_bus()[4:0]} | {16'h0, ralu_rn} | {16'h0, ralu_s}, 32'd0);
      sys_rst_n = 1'b1;
      @(negedge sysclk);

      // Multiply vectors
      do_op(1'b0, 16'h0003, 16'h0005, 0, 1'b0);
      check("mpy_3x5", {res_hi, res_lo}, 32'h0000000F);
      after_done(16'h0000, 16'h000F);
      do_op(1'b0, 16'hFFFF, 16'hFFFF, 0, 1'b0);
      check("mpy_ffff_ovf", {15'h0, ovf, res_hi}, {15'h0, 1'b1, 16'hFFFE});
      after_done(16'hFFFE, 16'h0001);
      do_op(1'b0, 16'h1234, 16'h00AB, 0, 1'b0);
      after_done(16'h000C, 16'h28BC);

      // Divide vectors
      do_op(1'b1, 16'h0064, 16'h0007, 0, 1'b0);
      check("div_100_7", {res_hi, res_lo}, 32'h0002000E);
      after_done(16'h0002, 16'h000E);
      do_op(1'b1, 16'hFFFF, 16'h8000, 0, 1'b0);
      check("div_ffff_8000", {res_hi, res_lo}, 32'h7FFF0001);
      after_done(16'h7FFF, 16'h0001);
      do_op(1'b1, 16'h0005, 16'h0009, 0, 1'b0);
      after_done(16'h0005, 16'h0000);

      // Divide by zero: one-cycle latency, no iterations
      do_op(1'b1, 16'h1234, 16'h0000, 0, 1'b0);
      check("dz_result", {res_hi, res_lo}, 32'h1234FFFF);
      after_done(16'h1234, 16'hFFFF);

      // Foreign start during ITER cycle 5 must be ignored
      do_op(1'b0, 16'h00C8, 16'h0103, 6, 1'b0);
      after_done(16'h0000, 16'hCA58);

      // Start held through DONE is taken on the first IDLE cycle
      do_op(1'b1, 16'h03E8, 16'h0021, 0, 1'b1);
      opa = 16'h0007;
      opb = 16'h0006;
      op  = 1'b0;
      @(negedge sysclk);
      check("held_start_idle", {30'h0, busy, start}, 32'd1);
      do_op(1'b0, 16'h0007, 16'h0006, 0, 1'b0);
      after_done(16'h0000, 16'h002A);

      // Reset in the middle of ITER
      op    = 1'b0;
      opa   = 16'h1111;
      opb   = 16'h2222;
      start = 1'b1;
      @(negedge sysclk);
      start = 1'b0;
      repeat (8) @(negedge sysclk);
      #2 sys_rst_n = 1'b0;
      #1;
      check("async_reset_flags", {28'h0, busy, done, ovf, dz}, 32'd0);
      check("async_reset_res", {res_hi, res_lo}, 32'd0);
      check("async_reset_ralu", {27'h0, ralu_bus()[4:0]} | {16'h0, ralu_rn} | {16'h0, ralu_s}, 32'd0);
      begin
         bit any_done;
         any_done = 1'b0;
         repeat (20) begin
            @(negedge sysclk);
            if (done) any_done = 1'b1;
         end
         sys_rst_n = 1'b1;
         repeat (10) begin
            @(negedge sysclk);
            if (done) any_done = 1'b1;
         end
         check("no_done_after_abort", {31'h0, any_done}, 32'd0);
      end
      do_op(1'b0, 16'h0002, 16'h0003, 0, 1'b0);
      check("mpy_after_reset", {res_hi, res_lo}, 32'h00000006);
      after_done(16'h0000, 16'h0006);

      check("scoreboard_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
